// File: rtl/snn_pkg.sv
// Shared definitions for the SNN datapath: encoder FSM states and the
// 16-bit Galois LFSR used for stochastic rate coding.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam int LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    // One Galois step: shift right and fold the tap mask in when a one drops out.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        return (s >> 1) ^ ({LFSR_WIDTH{s[0]}} & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps only when asked; shared by the spike encoder
// and the stochastic weight blocks.
module lfsr16 import snn_pkg::*; #(
    parameter logic [LFSR_WIDTH-1:0] seed = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] state
);

    // An all-zero state would lock the register, so reject it at elaboration.
    if (seed == '0) begin : g_bad_seed
        $error("lfsr16: seed must be nonzero");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/poisson_spike_encoder.sv
// Rate-coding input stage: latches a pixel frame and emits num_timesteps spike
// vectors, each channel firing when its pixel exceeds a rotated LFSR sample.
module poisson_spike_encoder import snn_pkg::*; #(
    parameter int                    num_channels  = 5,
    parameter int                    pixel_width   = 8,
    parameter int                    num_timesteps = 16,
    parameter logic [LFSR_WIDTH-1:0] lfsr_seed     = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [num_channels*pixel_width-1:0]   pixel_in,
    input  logic                                  load,
    input  logic                                  start,
    input  logic                                  spike_ready,
    output logic [num_channels-1:0]               spike_out,
    output logic                                  spike_valid,
    output logic [$clog2(num_timesteps+1)-1:0]    timestep,
    output logic                                  busy,
    output logic                                  done
);

    localparam int TS_W = $clog2(num_timesteps + 1);
    localparam logic [TS_W-1:0] LAST_TS = TS_W'(num_timesteps - 1);

    if (num_timesteps < 1) begin : g_bad_timesteps
        $error("poisson_spike_encoder: num_timesteps must be at least 1");
    end
    if (pixel_width > LFSR_WIDTH) begin : g_bad_width
        $error("poisson_spike_encoder: pixel_width cannot exceed the LFSR width");
    end

    enc_state_t                          enc_state;
    logic [num_channels*pixel_width-1:0] frame;
    logic [num_channels*pixel_width-1:0] start_frame;
    logic [LFSR_WIDTH-1:0]               lfsr_state;
    logic [LFSR_WIDTH-1:0]               lfsr_next;
    logic [num_channels-1:0]             spikes_first;
    logic [num_channels-1:0]             spikes_next;
    logic                                handshake;
    logic                                last_step;
    logic                                unused_lfsr_next;

    assign handshake   = spike_valid & spike_ready;
    assign last_step   = (timestep == LAST_TS);
    assign lfsr_next   = lfsr_step(lfsr_state);
    assign start_frame = load ? pixel_in : frame;

    // With few channels not every bit of the stepped word reaches a comparator.
    assign unused_lfsr_next = ^lfsr_next;

    lfsr16 #(
        .seed    (lfsr_seed)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (handshake),
        .state   (lfsr_state)
    );

    // Output vectors are registered, so each comparator bank looks one LFSR step
    // ahead: the first vector uses the current word, later ones the stepped word.
    for (genvar c = 0; c < num_channels; c++) begin : g_chan
        logic [pixel_width-1:0] r_first;
        logic [pixel_width-1:0] r_next;

        for (genvar b = 0; b < pixel_width; b++) begin : g_bit
            localparam int SRC = (b - (c % LFSR_WIDTH) + LFSR_WIDTH) % LFSR_WIDTH;
            assign r_first[b] = lfsr_state[SRC];
            assign r_next[b]  = lfsr_next[SRC];
        end

        assign spikes_first[c] = start_frame[c*pixel_width +: pixel_width] > r_first;
        assign spikes_next[c]  = frame[c*pixel_width +: pixel_width] > r_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_state   <= IDLE;
            frame       <= '0;
            spike_out   <= '0;
            spike_valid <= 1'b0;
            timestep    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (enc_state)
                IDLE: begin
                    if (load) begin
                        frame <= pixel_in;
                    end
                    if (start) begin
                        enc_state   <= RUN;
                        busy        <= 1'b1;
                        spike_valid <= 1'b1;
                        timestep    <= '0;
                        spike_out   <= spikes_first;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (last_step) begin
                            enc_state   <= DONE;
                            busy        <= 1'b0;
                            spike_valid <= 1'b0;
                            spike_out   <= '0;
                            timestep    <= '0;
                            done        <= 1'b1;
                        end else begin
                            timestep  <= timestep + TS_W'(1);
                            spike_out <= spikes_next;
                        end
                    end
                end
                DONE: begin
                    if (load) begin
                        frame <= pixel_in;
                    end
                    enc_state <= IDLE;
                end
                default: begin
                    enc_state   <= IDLE;
                    spike_out   <= '0;
                    spike_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poisson_spike_encoder.sv
// Self-checking bench for poisson_spike_encoder: table vectors, frame runs with
// optional backpressure, and a transaction-level LFSR/rotate/compare model.
module tb_poisson_spike_encoder;

    localparam int NCH = 5;
    localparam int PW  = 8;
    localparam int NTS = 16;
    localparam int TSW = $clog2(NTS + 1);

    typedef logic [NCH*PW-1:0] frame_t;
    typedef logic [NCH-1:0]    vec_t;

    typedef struct {
        frame_t pix;
        vec_t   first_a;
        vec_t   first_b;
    } vec_rec_t;

    logic           clk = 1'b0;
    logic           rst;
    frame_t         pixel_in;
    logic           load;
    logic           start;
    logic           spike_ready;
    vec_t           spike_a, spike_b;
    logic           valid_a, valid_b;
    logic [TSW-1:0] ts_a, ts_b;
    logic           busy_a, busy_b;
    logic           done_a, done_b;

    int total = 0;
    int bad   = 0;

    vec_t        rec_a [NTS];
    vec_t        rec_b [NTS];
    vec_t        first_frame_a [NTS];
    int          hs_count;
    int          done_cycle;
    int          stall_count;
    logic [15:0] model_a;
    logic [15:0] model_b;

    always #5 clk = ~clk;

    poisson_spike_encoder #(
        .num_channels (NCH), .pixel_width (PW), .num_timesteps (NTS), .lfsr_seed (16'hACE1)
    ) dut (
        .clk (clk), .rst (rst), .pixel_in (pixel_in), .load (load), .start (start),
        .spike_ready (spike_ready), .spike_out (spike_a), .spike_valid (valid_a),
        .timestep (ts_a), .busy (busy_a), .done (done_a)
    );

    poisson_spike_encoder #(
        .num_channels (NCH), .pixel_width (PW), .num_timesteps (NTS), .lfsr_seed (16'h0001)
    ) dut_g (
        .clk (clk), .rst (rst), .pixel_in (pixel_in), .load (load), .start (start),
        .spike_ready (spike_ready), .spike_out (spike_b), .spike_valid (valid_b),
        .timestep (ts_b), .busy (busy_b), .done (done_b)
    );

    function automatic frame_t pack5(input int p0, input int p1, input int p2, input int p3, input int p4);
        frame_t f;
        f[0*PW +: PW] = PW'(p0);
        f[1*PW +: PW] = PW'(p1);
        f[2*PW +: PW] = PW'(p2);
        f[3*PW +: PW] = PW'(p3);
        f[4*PW +: PW] = PW'(p4);
        return f;
    endfunction

    // Reference: halve the word, xor in 0xB400 when the dropped bit was one.
    function automatic logic [15:0] model_step(input logic [15:0] l);
        int v;
        int n;
        v = int'(l);
        n = v / 2;
        if (v % 2 == 1) n = n ^ 'hB400;
        return 16'(n);
    endfunction

    function automatic vec_t model_vector(input frame_t f, input logic [15:0] l);
        vec_t v;
        int   w;
        w = int'(l);
        for (int c = 0; c < NCH; c++) begin
            int rot;
            int r;
            int p;
            rot  = ((w << c) | (w >> (16 - c))) & 'hFFFF;
            r    = rot % 256;
            p    = int'(f[c*PW +: PW]);
            v[c] = (p > r);
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; load = 1'b0; start = 1'b0; spike_ready = 1'b0; pixel_in = '0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        model_a = 16'hACE1;
        model_b = 16'h0001;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput($sformatf("%s_spike", tag), {spike_a, spike_b}, '0);
        checkOutput($sformatf("%s_valid", tag), {valid_a, valid_b}, '0);
        checkOutput($sformatf("%s_timestep", tag), {ts_a, ts_b}, '0);
        checkOutput($sformatf("%s_busy", tag), {busy_a, busy_b}, '0);
        checkOutput($sformatf("%s_done", tag), {done_a, done_b}, '0);
    endtask

    task automatic applyStimulus(input vec_rec_t v, input int idx);
        do_reset(1);
        pixel_in = v.pix; load = 1'b1; start = 1'b1; spike_ready = 1'b0;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        checkOutput($sformatf("vec%0d_spike_a", idx), spike_a, v.first_a);
        checkOutput($sformatf("vec%0d_spike_b", idx), spike_b, v.first_b);
        checkOutput($sformatf("vec%0d_valid", idx), valid_a, 1);
        checkOutput($sformatf("vec%0d_busy", idx), busy_a, 1);
        checkOutput($sformatf("vec%0d_timestep", idx), ts_a, 0);
    endtask

    // Starts a frame with load+start and collects the accepted vectors.
    task automatic run_frame(input frame_t pix, input bit random_ready, input bit noise);
        vec_t           prev_a;
        logic [TSW-1:0] prev_ts;
        bit             stalled;
        bit             got_done;
        int             cyc;
        for (int t = 0; t < NTS; t++) begin
            rec_a[t] = 'x;
            rec_b[t] = 'x;
        end
        pixel_in = pix; load = 1'b1; start = 1'b1; spike_ready = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        hs_count = 0; stall_count = 0; done_cycle = -1;
        stalled = 1'b0; got_done = 1'b0; cyc = 1;
        prev_a = '0; prev_ts = '0;
        while (!got_done && cyc <= 300) begin
            if (stalled) begin
                checkOutput("stall_spike", spike_a, prev_a);
                checkOutput("stall_timestep", ts_a, prev_ts);
            end
            if (done_a) begin
                got_done   = 1'b1;
                done_cycle = cyc;
                checkOutput("done_pair", done_b, 1);
                checkOutput("done_busy", busy_a, 0);
                checkOutput("done_valid", valid_a, 0);
                checkOutput("done_spike", spike_a, 0);
            end else begin
                spike_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (noise) begin
                    start    = 1'b1;
                    load     = 1'b1;
                    pixel_in = frame_t'({$urandom, $urandom});
                end
                if (valid_a && spike_ready) begin
                    if (hs_count < NTS) begin
                        rec_a[hs_count] = spike_a;
                        rec_b[hs_count] = spike_b;
                    end
                    checkOutput("timestep_seq", ts_a, hs_count);
                    hs_count++;
                end
                stalled = valid_a && !spike_ready;
                if (stalled) stall_count++;
                prev_a  = spike_a;
                prev_ts = ts_a;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0; load = 1'b0; spike_ready = 1'b1;
        checkOutput("frame_done_seen", got_done, 1);
        checkOutput("handshakes", hs_count, NTS);
        checkOutput("done_cycle", done_cycle, NTS + stall_count + 1);
        @(negedge clk);
        checkOutput("done_one_cycle", done_a, 0);
        checkOutput("idle_busy", busy_a, 0);
        if (noise) begin
            @(negedge clk);
            checkOutput("no_second_frame", {busy_a, valid_a}, 0);
        end
    endtask

    task automatic score_frame(input frame_t pix, input string tag);
        for (int t = 0; t < NTS; t++) begin
            checkOutput($sformatf("%s_a_t%0d", tag, t), rec_a[t], model_vector(pix, model_a));
            checkOutput($sformatf("%s_b_t%0d", tag, t), rec_b[t], model_vector(pix, model_b));
            model_a = model_step(model_a);
            model_b = model_step(model_b);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_rec_t    vectors [6];
        frame_t      golden_pix;
        frame_t      extreme_pix;
        frame_t      rate_pix;
        vec_t        prev_rec [NTS];
        int          dut_cnt [NCH];
        int          model_cnt [NCH];
        int          same_frames;
        int          cnt_sum;
        logic [15:0] walk;
        bit          same;

        vectors[0] = '{pack5(0, 255, 0, 255, 0),       5'b01010, 5'b01010};
        vectors[1] = '{pack5(128, 64, 200, 10, 255),   5'b10100, 5'b11111};
        vectors[2] = '{pack5(255, 255, 255, 255, 255), 5'b11111, 5'b11111};
        vectors[3] = '{pack5(226, 196, 135, 14, 27),   5'b11111, 5'b11111};
        vectors[4] = '{pack5(225, 195, 134, 13, 26),   5'b00000, 5'b11111};
        vectors[5] = '{pack5(0, 0, 0, 0, 0),           5'b00000, 5'b00000};
        golden_pix  = pack5(128, 64, 200, 10, 255);
        extreme_pix = pack5(0, 255, 0, 255, 0);
        rate_pix    = pack5(64, 64, 64, 64, 64);

        do_reset(2);
        check_reset_outputs("por");
        checkOutput("por_lfsr_a", dut.lfsr_state, 16'hACE1);
        checkOutput("por_lfsr_b", dut_g.lfsr_state, 16'h0001);

        for (int i = 0; i < 6; i++) applyStimulus(vectors[i], i);

        do_reset(1);
        run_frame(golden_pix, 1'b0, 1'b0);
        checkOutput("golden_done_cycle", done_cycle, 17);
        for (int t = 0; t < NTS; t++) first_frame_a[t] = rec_a[t];
        score_frame(golden_pix, "golden");

        do_reset(1);
        run_frame(extreme_pix, 1'b0, 1'b0);
        checkOutput("extreme_done_cycle", done_cycle, 17);
        for (int t = 0; t < NTS; t++) checkOutput($sformatf("extreme_silent_t%0d", t), rec_a[t] & 5'b10101, 0);
        score_frame(extreme_pix, "extreme");

        do_reset(1);
        run_frame(golden_pix, 1'b1, 1'b0);
        for (int t = 0; t < NTS; t++) checkOutput($sformatf("stall_seq_t%0d", t), rec_a[t], first_frame_a[t]);
        score_frame(golden_pix, "stall");

        do_reset(1);
        pixel_in = golden_pix; load = 1'b1; start = 1'b1; spike_ready = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrun_rst1");
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrun_rst2");
        checkOutput("midrun_lfsr_a", dut.lfsr_state, 16'hACE1);
        checkOutput("midrun_lfsr_b", dut_g.lfsr_state, 16'h0001);
        model_a = 16'hACE1;
        model_b = 16'h0001;
        run_frame(golden_pix, 1'b0, 1'b0);
        for (int t = 0; t < NTS; t++) checkOutput($sformatf("rerun_seq_t%0d", t), rec_a[t], first_frame_a[t]);
        score_frame(golden_pix, "rerun");

        do_reset(1);
        pixel_in = pack5(255, 255, 255, 255, 255); load = 1'b1; start = 1'b0;
        @(negedge clk);
        load = 1'b0;
        run_frame(extreme_pix, 1'b0, 1'b1);
        score_frame(extreme_pix, "control");

        do_reset(1);
        same_frames = 0;
        for (int c = 0; c < NCH; c++) begin
            dut_cnt[c]   = 0;
            model_cnt[c] = 0;
        end
        for (int t = 0; t < NTS; t++) prev_rec[t] = '0;
        for (int f = 0; f < 64; f++) begin
            run_frame(rate_pix, 1'b0, 1'b0);
            walk = model_a;
            same = 1'b1;
            for (int t = 0; t < NTS; t++) begin
                for (int c = 0; c < NCH; c++) begin
                    dut_cnt[c]   += int'(rec_a[t][c]);
                    model_cnt[c] += int'(model_vector(rate_pix, walk) >> c) & 1;
                end
                walk = model_step(walk);
                if (f > 0 && rec_a[t] !== prev_rec[t]) same = 1'b0;
                prev_rec[t] = rec_a[t];
            end
            if (f > 0 && same) same_frames++;
            score_frame(rate_pix, $sformatf("rate_f%0d", f));
        end
        cnt_sum = 0;
        for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("rate_count_ch%0d", c), dut_cnt[c], model_cnt[c]);
            cnt_sum += dut_cnt[c];
        end
        checkOutput("rate_window", (cnt_sum >= NCH * 226) && (cnt_sum <= NCH * 286), 1);
        checkOutput("frames_differ", same_frames, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/poisson_spike_encoder.md
# poisson_spike_encoder

Rate-coding input stage for the SNN datapath. It latches one frame of pixel intensities and, over a fixed number of timesteps, emits one spike vector per timestep. Each channel fires with probability proportional to its intensity, using a shared 16-bit LFSR. The spike vector drives the `spike_in` bus of the integrate-and-fire neuron layer directly downstream.

## Interface
Parameters:
- `num_channels`, 5: number of spike channels (one pixel per channel).
- `pixel_width`, 8: intensity width per channel.
- `num_timesteps`, 16: timesteps per frame, at least 1.
- `lfsr_seed`, 16'hACE1: LFSR reset value. Must be nonzero; zero is an elaboration error.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `pixel_in`  in  num_channels*pixel_width: frame data, channel c at bits [c*pixel_width +: pixel_width].
- `load`  in  1: latch `pixel_in` into the frame register.
- `start`  in  1: begin encoding the latched frame.
- `spike_ready`  in  1: downstream accepts the current vector.
- `spike_out`  out  num_channels: spike vector for the current timestep.
- `spike_valid`  out  1: `spike_out` is valid.
- `timestep`  out  $clog2(num_timesteps+1): index of the current timestep.
- `busy`  out  1: encoder is in RUN.
- `done`  out  1: one-cycle pulse after the last vector is accepted.

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: presents one spike vector per timestep.
  - DONE: asserts `done` for one cycle.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when a handshake occurs (`spike_valid & spike_ready`) at `timestep == num_timesteps-1`.
  - DONE→IDLE unconditionally.
- Frame register:
  - Loaded from `pixel_in` on `load` in IDLE or DONE.
  - `load` is ignored in RUN.
  - If `load` and `start` are high in the same IDLE cycle, the frame is latched and RUN encodes the new data.
- LFSR:
  - Galois, polynomial x^16+x^14+x^13+x^11+1, taps 16'hB400.
  - Advances exactly once per handshake and holds otherwise.
  - Does not reseed between frames; only `rst` restores `lfsr_seed`.
- Spike rule, for state L in timestep t:
  - Random value for channel c: r_c = low `pixel_width` bits of L rotated left by c.
  - `spike_out[c] = (pixel[c] > r_c)`, unsigned compare.
  - Pixel 0 never fires. Pixel 2^pixel_width-1 fires unless r_c is all ones.
- Handshake:
  - While `spike_valid` is high and `spike_ready` is low, `spike_out` and `timestep` hold stable.
  - `spike_valid` is never withdrawn before acceptance.
- `start` in RUN or DONE is ignored; it is not queued.
- Outputs `spike_out`, `spike_valid`, `timestep`, `busy` and `done` are driven from registers or a decode of state only. There is no combinational path from any input.

## Timing
- Reset values:
  - State IDLE, LFSR = `lfsr_seed`, frame register = 0.
  - `spike_out` = 0, `spike_valid` = 0, `timestep` = 0, `busy` = 0, `done` = 0.
- `start` sampled high in IDLE at edge k gives `busy` = `spike_valid` = 1 from cycle k+1, with `timestep` = 0.
- With `spike_ready` held high, one vector is accepted per cycle. A frame takes exactly `num_timesteps` cycles in RUN, then 1 cycle in DONE.
- Outside RUN, `spike_out` is 0 and `spike_valid` is 0.
- `rst` mid-RUN: the next cycle shows the full reset values, and any in-flight vector is dropped.
- With `num_timesteps` = 1, RUN lasts one accepted vector.

## Structure
- Shared package `snn_pkg` holds:
  - the encoder state enum (IDLE, RUN, DONE);
  - `LFSR_WIDTH` = 16 and `LFSR_TAPS` = 16'hB400.
- Sub-module `lfsr16` has ports `clk`, `rst`, `advance`, `state`, with the seed as a parameter. It is reused later by stochastic weight blocks.
- The comparators are a generate loop over channels in the top module.

## Test plan
- Reset:
  - Drive `rst` for 2 cycles mid-RUN.
  - Require all outputs 0 the following cycle and LFSR = 16'hACE1. A fresh `start` reproduces the vectors of the first frame after power-up.
- Extremes:
  - Load pixels {0, 255, 0, 255, 0} with `spike_ready` = 1 and 16 timesteps.
  - Require channels 0, 2 and 4 never spike, channels 1 and 3 spike except where r_c = 8'hFF, and `done` pulses at the 17th cycle after `start`.
- Golden model:
  - Use seed 16'h0001 and pixels {128, 64, 200, 10, 255}.
  - Require `spike_out` to match a reference LFSR/rotate/compare model bit-exactly for 16 timesteps.
- Backpressure:
  - Toggle `spike_ready` randomly at 50%.
  - Require `spike_out` and `timestep` stable while stalled, the same vector sequence as with no stalls, and exactly 16 handshakes per frame.
- Control corner cases:
  - `load` and `start` in the same cycle: the new frame is used.
  - `start` during RUN: ignored, with no second frame.
  - `load` during RUN: the frame register is unchanged.
- Rate check:
  - Set pixel = 64 on all channels, run 64 frames back to back.
  - Require the spike count per channel within 25% ±3% of timesteps, and consecutive frames must differ (LFSR not reseeded).
